sdram_async_fifo: RTL

Parametrised dual-clock FIFO for crossing SDRAM controller data between the user write domain (w_clk) and the read domain (r_clk). It generalises the earlier fixed-size FIFO: configurable width and depth, a selectable first-word-fall-through (FWFT) read mode, per-side occupancy counts, programmable almost-full and almost-empty thresholds, and overflow/underflow error pulses. Pointers cross domains as registered Gray code through two-flop synchronisers.

---
 rtl/sdram_async_fifo.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sdram_async_fifo.sv
// Dual-clock FIFO carrying SDRAM controller data from the w_clk domain to the r_clk domain.
// Gray-coded pointers cross through two-flop synchronisers; optional first-word-fall-through output.
`timescale 1ns/1ps
module sdram_async_fifo #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int AFULL_TH  = (1 << ADDR_W) - 4,
    parameter int AEMPTY_TH = 4,
    parameter bit FWFT      = 1'b0
) (
    input  logic              rst_n,
    // write domain
    input  logic              w_clk,
    input  logic              wen,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow,
    // read domain
    input  logic              r_clk,
    input  logic              ren,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);

    localparam int              PW       = ADDR_W + 1;
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [PW-1:0]   DEPTH_V  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0]   AFULL_V  = PW'(AFULL_TH);
    localparam logic [PW-1:0]   AEMPTY_V = PW'(AEMPTY_TH);

    function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PW-1:0] wptr_q, wptr_d, wgray_q;
    logic [PW-1:0] rgray_s1_q, rgray_s2_q, rptr_s, wr_cnt;
    logic [PW-1:0] rgray_q;
    logic          wr_acc, overflow_q;

    always_comb begin
        rptr_s = g2b(rgray_s2_q);
        wr_cnt = wptr_q - rptr_s;
        wr_acc = wen && (wr_cnt != DEPTH_V);
        wptr_d = wptr_q + PW'(wr_acc);
    end

    // Gray is registered from the next binary value so it changes on the same edge as wptr.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            wgray_q    <= '0;
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            wgray_q    <= b2g(wptr_d);
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
            overflow_q <= wen && (wr_cnt == DEPTH_V);
        end
    end

    always_ff @(posedge w_clk) begin
        if (wr_acc) mem[wptr_q[ADDR_W-1:0]] <= din;
    end

    assign full        = (wr_cnt == DEPTH_V);
    assign almost_full = (wr_cnt >= AFULL_V);
    assign wr_count    = wr_cnt;
    assign overflow    = overflow_q;

    // ---------------- read domain ----------------
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     wgray_s1_q, wgray_s2_q, wptr_s, mem_cnt, rd_cnt;
    logic              ov_q, ov_d, rd_en, empty_w, rvalid_q, underflow_q;
    logic [DATA_W-1:0] dout_q;

    // In FWFT mode rptr advances when a word moves into the output register,
    // so mem_cnt counts only words still waiting in memory.
    always_comb begin
        wptr_s  = g2b(wgray_s2_q);
        mem_cnt = wptr_s - rptr_q;
        if (FWFT) begin
            empty_w = !ov_q;
            rd_en   = (mem_cnt != '0) && (!ov_q || ren);
            ov_d    = rd_en || (ov_q && !ren);
            rd_cnt  = mem_cnt + PW'(ov_q);
        end else begin
            empty_w = (mem_cnt == '0);
            rd_en   = ren && !empty_w;
            ov_d    = 1'b0;
            rd_cnt  = mem_cnt;
        end
        rptr_d = rptr_q + PW'(rd_en);
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q      <= '0;
            rgray_q     <= '0;
            wgray_s1_q  <= '0;
            wgray_s2_q  <= '0;
            ov_q        <= 1'b0;
            rvalid_q    <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            rptr_q      <= rptr_d;
            rgray_q     <= b2g(rptr_d);
            wgray_s1_q  <= wgray_q;
            wgray_s2_q  <= wgray_s1_q;
            ov_q        <= ov_d;
            rvalid_q    <= rd_en;
            underflow_q <= ren && empty_w;
            if (rd_en) dout_q <= mem[rptr_q[ADDR_W-1:0]];
        end
    end

    assign dout         = dout_q;
    assign rd_valid     = FWFT ? ov_q : rvalid_q;
    assign empty        = empty_w;
    assign almost_empty = (rd_cnt <= AEMPTY_V);
    assign rd_count     = rd_cnt;
    assign underflow    = underflow_q;

endmodule
